// File: rtl/ila_pkg.sv
// Shared types for the ILA trigger sequencer: state encoding, config
// register map and CTRL bit positions.
package ila_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WAIT_A = 3'd1,
      ST_WAIT_B = 3'd2,
      ST_POST   = 3'd3,
      ST_DONE   = 3'd4
   } seq_state_e;

   localparam logic [2:0] ADDR_MASK_A   = 3'd0;
   localparam logic [2:0] ADDR_VAL_A    = 3'd1;
   localparam logic [2:0] ADDR_MASK_B   = 3'd2;
   localparam logic [2:0] ADDR_VAL_B    = 3'd3;
   localparam logic [2:0] ADDR_POST_CNT = 3'd4;
   localparam logic [2:0] ADDR_CTRL     = 3'd5;

   localparam int CTRL_TWO_STAGE = 0;

   // A sequence is "running" while capture is enabled; config is frozen then.
   function automatic logic is_running(input seq_state_e s);
      return (s == ST_WAIT_A) || (s == ST_WAIT_B) || (s == ST_POST);
   endfunction

endpackage

// File: rtl/ila_trigger_seq_if.sv
// Bundle of event, config, control and status signals between the ILA
// front end (master) and the trigger sequencer (slave).
interface ila_trigger_seq_if #(
   parameter int EVW = 16
);
   logic [EVW-1:0] events;
   logic           cfg_we;
   logic [2:0]     cfg_addr;
   logic [EVW-1:0] cfg_wdata;
   logic           arm;
   logic           abort;
   logic           trig;
   logic           capture_en;
   logic           done;
   logic           cfg_err;
   logic [2:0]     seq_state;

   modport master (
      output events, cfg_we, cfg_addr, cfg_wdata, arm, abort,
      input  trig, capture_en, done, cfg_err, seq_state
   );

   modport slave (
      input  events, cfg_we, cfg_addr, cfg_wdata, arm, abort,
      output trig, capture_en, done, cfg_err, seq_state
   );
endinterface

// File: rtl/ila_stage_match.sv
// One trigger stage comparator: every masked event bit must equal the
// reference value; an all-zero mask matches unconditionally.
module ila_stage_match #(
   parameter int EVW = 16
) (
   input  logic [EVW-1:0] events_i,
   input  logic [EVW-1:0] mask_i,
   input  logic [EVW-1:0] value_i,
   output logic           match_o
);
   assign match_o = ((events_i ^ value_i) & mask_i) == '0;
endmodule

// File: rtl/ila_trigger_seq.sv
// Two-stage ILA trigger sequencer: matches event patterns, fires one trig
// pulse to sump2 and holds capture enabled for a post-trigger window.
module ila_trigger_seq
   import ila_pkg::*;
#(
   parameter int EVW  = 16,
   parameter int CNTW = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   ila_trigger_seq_if.slave    bus
);

   logic [EVW-1:0]  mask_a_q, val_a_q, mask_b_q, val_b_q;
   logic [CNTW-1:0] post_cnt_q;
   logic            two_stage_q;
   logic            cfg_err_q;

   seq_state_e      state_q;
   logic [CNTW-1:0] cnt_q;
   logic            trig_q, capture_en_q, done_q;

   logic            match_a, match_b, fire_d;

   ila_stage_match #(.EVW(EVW)) u_match_a (
      .events_i (bus.events),
      .mask_i   (mask_a_q),
      .value_i  (val_a_q),
      .match_o  (match_a)
   );

   ila_stage_match #(.EVW(EVW)) u_match_b (
      .events_i (bus.events),
      .mask_i   (mask_b_q),
      .value_i  (val_b_q),
      .match_o  (match_b)
   );

   // Writes are only accepted while no sequence is running, so a live
   // sequence always compares against a stable configuration.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mask_a_q    <= '0;
         val_a_q     <= '0;
         mask_b_q    <= '0;
         val_b_q     <= '0;
         post_cnt_q  <= '0;
         two_stage_q <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         cfg_err_q <= 1'b0;
         if (bus.cfg_we && (bus.cfg_addr <= ADDR_CTRL)) begin
            if (is_running(state_q)) begin
               cfg_err_q <= 1'b1;
            end else begin
               case (bus.cfg_addr)
                  ADDR_MASK_A:   mask_a_q    <= bus.cfg_wdata;
                  ADDR_VAL_A:    val_a_q     <= bus.cfg_wdata;
                  ADDR_MASK_B:   mask_b_q    <= bus.cfg_wdata;
                  ADDR_VAL_B:    val_b_q     <= bus.cfg_wdata;
                  ADDR_POST_CNT: post_cnt_q  <= CNTW'(bus.cfg_wdata);
                  ADDR_CTRL:     two_stage_q <= bus.cfg_wdata[CTRL_TWO_STAGE];
                  default: ;
               endcase
            end
         end
      end
   end

   assign fire_d = ((state_q == ST_WAIT_A) && match_a && !two_stage_q) ||
                   ((state_q == ST_WAIT_B) && match_b);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         trig_q       <= 1'b0;
         capture_en_q <= 1'b0;
         done_q       <= 1'b0;
      end else if (bus.abort) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         trig_q       <= 1'b0;
         capture_en_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         trig_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (bus.arm) begin
                  state_q      <= ST_WAIT_A;
                  capture_en_q <= 1'b1;
                  done_q       <= 1'b0;
               end
            end
            ST_WAIT_A: begin
               if (match_a && two_stage_q) state_q <= ST_WAIT_B;
            end
            ST_WAIT_B: ;
            ST_POST: begin
               cnt_q <= cnt_q - CNTW'(1);
               if (cnt_q == CNTW'(1)) begin
                  state_q      <= ST_DONE;
                  capture_en_q <= 1'b0;
                  done_q       <= 1'b1;
               end
            end
            default: begin
               state_q      <= ST_IDLE;
               capture_en_q <= 1'b0;
            end
         endcase
         // A zero-length post window skips POST and completes immediately.
         if (fire_d) begin
            trig_q <= 1'b1;
            cnt_q  <= post_cnt_q;
            if (post_cnt_q != '0) begin
               state_q      <= ST_POST;
               capture_en_q <= 1'b1;
            end else begin
               state_q      <= ST_DONE;
               capture_en_q <= 1'b0;
               done_q       <= 1'b1;
            end
         end
      end
   end

   assign bus.trig       = trig_q;
   assign bus.capture_en = capture_en_q;
   assign bus.done       = done_q;
   assign bus.cfg_err    = cfg_err_q;
   assign bus.seq_state  = state_q;

endmodule

// File: doc/ila_trigger_seq.md
ILA_TRIGGER_SEQ -- requirements
Module: ila_trigger_seq

Interface
REQ-001 Parameters: EVW, default 16, event bus width; CNTW, default 16, post-trigger counter width.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 events  input  EVW  synchronized ILA event bus (data_in, strobe, FSM state, data_out).
REQ-005 cfg_we  input  1  config write strobe, one cycle per write.
REQ-006 cfg_addr  input  3  config register select.
REQ-007 cfg_wdata  input  EVW  config write data.
REQ-008 arm  input  1  start-sequence pulse.
REQ-009 abort  input  1  cancel pulse; priority over arm.
REQ-010 trig  output  1  one-cycle trigger pulse to sump2 capture logic.
REQ-011 capture_en  output  1  high while a sequence is running (WAIT_A, WAIT_B, POST).
REQ-012 done  output  1  sticky sequence-complete flag.
REQ-013 cfg_err  output  1  one-cycle pulse on a rejected config write.
REQ-014 seq_state  output  3  current state encoding, exported for ILA observation.

Function
REQ-015 Config registers: 0 MASK_A, 1 VAL_A, 2 MASK_B, 3 VAL_B, 4 POST_CNT (low CNTW bits), 5 CTRL (bit0 = TWO_STAGE); addresses 6-7 are write-ignored with no cfg_err.
REQ-016 Stage match: match_X = ((events XOR VAL_X) AND MASK_X) == 0; MASK_X = 0 matches every cycle.
REQ-017 States and encoding: IDLE=0, WAIT_A=1, WAIT_B=2, POST=3, DONE=4; seq_state equals the current state.
REQ-018 IDLE or DONE, arm=1, abort=0 -> WAIT_A next cycle; done clears in the same cycle.
REQ-019 WAIT_A, match_A: TWO_STAGE=1 -> WAIT_B; TWO_STAGE=0 -> trigger event.
REQ-020 WAIT_B, match_B -> trigger event; match_A has no effect in WAIT_B.
REQ-021 Trigger event sampled at edge N -> trig=1 for exactly cycle N+1; counter loads POST_CNT; POST_CNT>0 -> POST, else -> DONE.
REQ-022 POST: counter decrements each cycle; leaves POST after exactly POST_CNT cycles -> DONE, done=1.
REQ-023 abort=1 in any state -> IDLE next cycle; done=0, no trig, counter cleared.
REQ-024 arm while in WAIT_A, WAIT_B or POST is ignored (no restart).
REQ-025 cfg_we with state in WAIT_A, WAIT_B or POST: register unchanged, cfg_err=1 next cycle; in IDLE or DONE: write takes effect next cycle.
REQ-026 Simultaneous cfg_we and arm in IDLE: write is applied and the new value is used by the sequence starting that cycle.
REQ-027 All outputs registered; trig, cfg_err are never high for two consecutive cycles from one event.
REQ-028 capture_en = 1 iff state is WAIT_A, WAIT_B or POST.

Reset
REQ-029 rst_n=0 at an edge -> state IDLE, all config registers 0, counter 0, trig=0, capture_en=0, done=0, cfg_err=0.
REQ-030 Reset mid-sequence discards the sequence with no trig pulse; arm asserted with rst_n=0 is ignored.

Structure
REQ-031 Shared package ila_pkg holds the state enum, config address constants (ADDR_MASK_A..ADDR_CTRL) and CTRL bit index.
REQ-032 One sub-module ila_stage_match (events, mask, value -> match), instantiated twice.
REQ-033 Instantiated in top between the synchronizers and sump2_top; trig drives the sump2 external trigger, seq_state feeds spare event bits.

Verification
REQ-034 Single stage: MASK_A=0x000F, VAL_A=0x0005, POST_CNT=3, arm; events=0x0005 at edge N -> trig at N+1, POST 3 cycles, done=1 at N+4.
REQ-035 Two stage: TWO_STAGE=1, A=0x0010/0x0010, B=0x0020/0x0020; events 0x0020 then 0x0010 then 0x0020 -> trig only after the third value.
REQ-036 POST_CNT=0, MASK_A=0: arm -> WAIT_A, trig and DONE one cycle later, capture_en high exactly one cycle.
REQ-037 abort in POST with counter=2 -> IDLE next cycle, done=0; subsequent arm restarts normally.
REQ-038 cfg_we to ADDR_VAL_A in WAIT_A -> cfg_err pulse, VAL_A unchanged, match still uses old value.
REQ-039 rst_n low for one cycle in WAIT_B -> all outputs 0, config 0, no trig observed.
